// File: rtl/apb_master_param_if.sv
// Command/response and APB bus bundle for apb_master_param.
// Handshake: a command transfers on a clock edge where cmd_valid and cmd_ready are both 1; rsp_valid is a one-cycle pulse with no back-pressure.
interface apb_master_param_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8,
   parameter int NSLV   = 2
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic                   cmd_write;
   logic [ADDR_W-1:0]      cmd_addr;
   logic [DATA_W-1:0]      cmd_wdata;
   logic                   rsp_valid;
   logic [DATA_W-1:0]      rsp_rdata;
   logic                   rsp_err;
   logic [NSLV-1:0]        PSEL;
   logic                   PENABLE;
   logic                   PWRITE;
   logic [ADDR_W-1:0]      PADDR;
   logic [DATA_W-1:0]      PWDATA;
   logic [NSLV*DATA_W-1:0] PRDATA;
   logic [NSLV-1:0]        PREADY;
   logic [NSLV-1:0]        PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master_param.sv
// Single-outstanding APB master with address-decoded one-hot PSEL.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT wait cycles.
module apb_master_param #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 8,
   parameter int NSLV    = 2,
   parameter int TIMEOUT = 16
) (
   input  logic                PCLK,
   input  logic                PRESET,
   apb_master_param_if.master  bus,
   output logic [1:0]          dbg_state_o
);
   localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              pwrite_q, pwrite_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   logic [IDX_W-1:0]  idx;
   logic [4:0]        idx_ext;
   logic              decode_ok;
   logic [NSLV-1:0]   psel;
   logic              pready_sel, pslverr_sel, timeout_hit;
   logic [DATA_W-1:0] prdata_sel;

   assign idx       = paddr_q[ADDR_W-1 -: IDX_W];
   assign idx_ext   = 5'(idx);
   assign decode_ok = (idx_ext < 5'(NSLV));

   // Select and per-slave return mux; an out-of-range index selects nothing.
   always_comb begin
      psel        = '0;
      pready_sel  = 1'b0;
      pslverr_sel = 1'b0;
      prdata_sel  = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (state_q != IDLE && idx_ext == 5'(i)) begin
            psel[i]     = 1'b1;
            pready_sel  = bus.PREADY[i];
            pslverr_sel = bus.PSLVERR[i];
            prdata_sel  = bus.PRDATA[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef APB_MASTER_TIMEOUT_EN
   logic [7:0] wait_cnt_q, wait_cnt_d;

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (state_q == SETUP) begin
         wait_cnt_d = '0;
      end else if (state_q == ACCESS && !pready_sel && wait_cnt_q != 8'(TIMEOUT)) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) wait_cnt_q <= '0;
      else        wait_cnt_q <= wait_cnt_d;
   end

   assign timeout_hit = (state_q == ACCESS) && !pready_sel && (wait_cnt_q == 8'(TIMEOUT));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               state_d  = SETUP;
               paddr_d  = bus.cmd_addr;
               pwrite_d = bus.cmd_write;
               pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
            end
         end
         SETUP: begin
            if (decode_ok) begin
               state_d = ACCESS;
            end else begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end
         end
         ACCESS: begin
            if (pready_sel) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = pslverr_sel;
               rsp_rdata_d = pwrite_q ? '0 : prdata_sel;
            end else if (timeout_hit) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.PSEL      = psel;
   assign bus.PENABLE   = (state_q == ACCESS);
   assign bus.PWRITE    = pwrite_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PWDATA    = pwdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_apb_master_param.sv
// Bench for apb_master_param: random commands, reactive slave, scoreboard of expected responses.
`timescale 1ns/1ps
module tb_apb_master_param;
   localparam int ADDR_W  = 9;
   localparam int DATA_W  = 8;
   localparam int NSLV    = 3;
   localparam int TIMEOUT = 4;
   localparam int IDX_W   = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int EW      = DATA_W + 1 + 32;
`ifdef APB_MASTER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic       PCLK = 1'b0;
   logic       PRESET = 1'b1;
   logic [1:0] dbg_state;
   int         cyc = 0;

   apb_master_param_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV)) bus();

   apb_master_param #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV), .TIMEOUT(TIMEOUT)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .bus(bus), .dbg_state_o(dbg_state)
   );

   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int                total = 0;
   int                bad = 0;
   logic [EW-1:0]     exp_q[$];
   logic [EW-1:0]     e_item;
   int                t_start = 0, t_rsp = 0;
   logic [ADDR_W-1:0] t_addr = '0;
   logic              t_write = 1'b0;
   logic [DATA_W-1:0] t_wdata = '0;
   int                p_waits = 0;
   logic              p_err = 1'b0;
   logic [DATA_W-1:0] p_rdata = '0;
   logic [DATA_W-1:0] last_rdata = '0;
   logic              last_err = 1'b0;
   bit                mon_en = 1'b0;
   int                acc_n = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: response content and the absolute cycle of rsp_valid for a command accepted at cycle acc.
   function automatic logic [EW-1:0] model(input logic [ADDR_W-1:0] addr, input logic wr, input int waits,
                                           input logic serr, input logic [DATA_W-1:0] srd, input int acc);
      int idx;
      int rc;
      logic e;
      logic [DATA_W-1:0] rd;
      idx = int'(addr) >> (ADDR_W - IDX_W);
      if (idx >= NSLV) begin
         rc = acc + 2; e = 1'b1; rd = '0;
      end else if (TO_EN && waits > TIMEOUT) begin
         rc = acc + 3 + TIMEOUT; e = 1'b1; rd = '0;
      end else begin
         rc = acc + 3 + waits; e = serr; rd = wr ? '0 : srd;
      end
      return {rd, e, 32'(rc)};
   endfunction

   function automatic logic [NSLV-1:0] exp_psel(input logic [ADDR_W-1:0] addr);
      int idx;
      logic [NSLV-1:0] s;
      idx = int'(addr) >> (ADDR_W - IDX_W);
      s = '0;
      if (idx < NSLV) s[idx] = 1'b1;
      return s;
   endfunction

   // ---------------- driver tasks (drive at posedge + 1) ----------------
   task automatic poke();
      bus.cmd_valid = (bus.cmd_ready !== 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.cmd_write = 1'($urandom_range(0, 1));
      bus.cmd_addr  = ADDR_W'($urandom);
      bus.cmd_wdata = DATA_W'($urandom);
   endtask

   task automatic issue(input logic [ADDR_W-1:0] addr, input logic wr, input logic [DATA_W-1:0] wd,
                        input int waits, input logic serr, input logic [DATA_W-1:0] srd);
      int n;
      logic [EW-1:0] m;
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 600) begin
         poke();
         @(posedge PCLK); #1;
         n++;
      end
      if (n >= 600) begin
         chk("cmd_ready_wait", 64'(bus.cmd_ready), 64'(1));
         exp_q.delete();
      end
      p_waits = waits; p_err = serr; p_rdata = srd;
      t_addr = addr; t_write = wr; t_wdata = wd; t_start = cyc;
      m = model(addr, wr, waits, serr, srd, cyc);
      t_rsp = int'(m[31:0]);
      exp_q.push_back(m);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wd;
      @(posedge PCLK); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.cmd_ready !== 1'b1) && n < 600) begin
         poke();
         @(posedge PCLK); #1;
         n++;
      end
      bus.cmd_valid = 1'b0;
      chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_psel"},      64'(bus.PSEL),      64'(0));
      chk({tag, "_penable"},   64'(bus.PENABLE),   64'(0));
      chk({tag, "_pwrite"},    64'(bus.PWRITE),    64'(0));
      chk({tag, "_paddr"},     64'(bus.PADDR),     64'(0));
      chk({tag, "_pwdata"},    64'(bus.PWDATA),    64'(0));
      chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
      chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(0));
      chk({tag, "_rsp_err"},   64'(bus.rsp_err),   64'(0));
      chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
      chk({tag, "_state"},     64'(dbg_state),     64'(0));
   endtask

   // ---------------- reactive slave ----------------
   always @(posedge PCLK) begin
      #1;
      for (int i = 0; i < NSLV; i++) begin
         bus.PREADY[i]  = 1'($urandom_range(0, 1));
         bus.PSLVERR[i] = 1'($urandom_range(0, 1));
         bus.PRDATA[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      if (bus.PENABLE === 1'b1) begin
         for (int i = 0; i < NSLV; i++) begin
            if (bus.PSEL[i] === 1'b1) begin
               if (acc_n == p_waits) begin
                  bus.PREADY[i]  = 1'b1;
                  bus.PSLVERR[i] = p_err;
                  bus.PRDATA[i*DATA_W +: DATA_W] = p_rdata;
               end else begin
                  bus.PREADY[i] = 1'b0;
               end
            end
         end
         acc_n++;
      end else begin
         acc_n = 0;
      end
   end

   // ---------------- monitor (samples on negedge) ----------------
   always @(negedge PCLK) begin
      if (mon_en && PRESET == 1'b0) begin
         if (bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 64'(bus.rsp_valid), 64'(0));
            end else begin
               e_item = exp_q.pop_front();
               chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e_item[EW-1 -: DATA_W]));
               chk("rsp_err",   64'(bus.rsp_err),   64'(e_item[32]));
               chk("rsp_cycle", 64'(cyc),           64'(e_item[31:0]));
               chk("rsp_cmd_ready", 64'(bus.cmd_ready), 64'(1));
               last_rdata = e_item[EW-1 -: DATA_W];
               last_err   = e_item[32];
            end
         end else begin
            chk("hold_rdata", 64'(bus.rsp_rdata), 64'(last_rdata));
            chk("hold_err",   64'(bus.rsp_err),   64'(last_err));
         end
         if (cyc > t_start && cyc < t_rsp) begin
            chk("psel",    64'(bus.PSEL),    64'(exp_psel(t_addr)));
            chk("penable", 64'(bus.PENABLE), 64'(cyc >= t_start + 2));
            chk("paddr",   64'(bus.PADDR),   64'(t_addr));
            chk("pwrite",  64'(bus.PWRITE),  64'(t_write));
            chk("pwdata",  64'(bus.PWDATA),  64'(t_write ? t_wdata : '0));
         end else begin
            chk("idle_psel",    64'(bus.PSEL),    64'(0));
            chk("idle_penable", 64'(bus.PENABLE), 64'(0));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 9'h005;
      bus.cmd_wdata = 8'hA5;
      PRESET = 1'b1;
      repeat (3) @(posedge PCLK);
      #1;
      PRESET = 1'b0;
      bus.cmd_valid = 1'b0;
      reset_check("por");
      mon_en = 1'b1;

      issue(9'h005, 1'b1, 8'hA5, 0, 1'b0, 8'h00);
      issue(9'h10C, 1'b0, 8'h77, 3, 1'b0, 8'h3C);
      issue(9'h0AA, 1'b0, 8'h11, 0, 1'b1, 8'h5A);
      issue(9'h1C0, 1'b1, 8'hF0, 0, 1'b0, 8'h99);
      issue(9'h1C0, 1'b0, 8'h00, 2, 1'b0, 8'h42);
      issue(9'h080, 1'b0, 8'h00, TIMEOUT, 1'b1, 8'hC3);
      issue(9'h0FF, 1'b1, 8'h5E, TIMEOUT + 1, 1'b0, 8'h24);
      issue(9'h105, 1'b0, 8'h00, 100, 1'b0, 8'h6B);

      for (int k = 0; k < 40; k++) begin
         issue(ADDR_W'($urandom), 1'($urandom_range(0, 1)), DATA_W'($urandom),
               int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), DATA_W'($urandom));
      end
      drain();

      issue(9'h010, 1'b0, 8'h00, 30, 1'b0, 8'h81);
      @(posedge PCLK); #1;
      @(posedge PCLK); #1;
      chk("in_access", 64'(dbg_state), 64'(2));
      PRESET = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = 9'h006;
      exp_q.delete();
      t_start = 0;
      t_rsp = 0;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      bus.cmd_valid = 1'b0;
      last_rdata = '0;
      last_err = 1'b0;
      reset_check("mid_reset");

      for (int k = 0; k < 8; k++) begin
         issue(ADDR_W'($urandom), 1'($urandom_range(0, 1)), DATA_W'($urandom),
               int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), DATA_W'($urandom));
      end
      drain();
      repeat (3) @(posedge PCLK);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/apb_master_param.md
APB_MASTER_PARAM -- requirements
Module: apb_master_param

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 9, APB address width.
REQ-002 The block SHALL expose parameter DATA_W, default 8, APB data width.
REQ-003 The block SHALL expose parameter NSLV, default 2, number of slaves, range 1..16.
REQ-004 The block SHALL expose parameter TIMEOUT, default 16, the maximum number of wait cycles, range 1..255.
REQ-005 One clock; reset is synchronous and active-high: PCLK input 1 is the clock, and PRESET input 1 is the synchronous active-high reset.
REQ-006 cmd_valid input 1 requests a transfer; cmd_ready output 1 means a command is accepted this cycle.
REQ-007 cmd_write input 1 selects write (1) or read (0); cmd_addr input ADDR_W is the address; cmd_wdata input DATA_W is the write data.
REQ-008 rsp_valid output 1 is a one-cycle completion pulse; rsp_rdata output DATA_W is the read data; rsp_err output 1 is the error flag.
REQ-009 PSEL output NSLV is the one-hot select; PENABLE, PWRITE output 1; PADDR output ADDR_W; PWDATA output DATA_W.
REQ-010 PRDATA input NSLV*DATA_W carries slave read data, packed with slave i at bits [i*DATA_W +: DATA_W]; PREADY and PSLVERR are inputs of width NSLV, one bit per slave.

Function
REQ-011 The block SHALL use the states IDLE, SETUP and ACCESS, all registered on the rising edge of PCLK.
REQ-012 cmd_ready SHALL be 1 only in IDLE; when cmd_valid and cmd_ready are both 1, the block SHALL register cmd_addr, cmd_wdata and cmd_write into PADDR, PWDATA and PWRITE, and go to SETUP.
REQ-013 PADDR, PWDATA and PWRITE SHALL stay stable from SETUP until the transfer completes; PWDATA SHALL be 0 for reads.
REQ-014 The slave index SHALL be PADDR[ADDR_W-1 -: max(1,clog2(NSLV))]; in SETUP and ACCESS, PSEL[index] SHALL be 1 and all other PSEL bits 0.
REQ-015 If the slave index is >= NSLV, the block SHALL assert no PSEL bit, return to IDLE from SETUP, and pulse rsp_valid with rsp_err=1 and rsp_rdata=0 (decode error).
REQ-016 In SETUP, PENABLE SHALL be 0, and the next state SHALL be ACCESS, unconditionally for a valid decode.
REQ-017 In ACCESS, PENABLE SHALL be 1; the block SHALL stay in ACCESS while PREADY[index] is 0.
REQ-018 On ACCESS with PREADY[index]=1, the block SHALL go to IDLE; on the next cycle it SHALL pulse rsp_valid with rsp_err=PSLVERR[index] and rsp_rdata=PRDATA slice[index] for reads, or 0 for writes.
REQ-019 The minimum latency SHALL be: accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid and cmd_ready at 3; each wait cycle SHALL add one cycle.
REQ-020 PSLVERR and PRDATA SHALL be sampled only in the ACCESS cycle with PREADY=1, and ignored otherwise.
REQ-021 rsp_rdata and rsp_err SHALL hold their values until the next rsp_valid.
REQ-022 cmd_valid while busy SHALL be ignored, with no buffering.

Reset
REQ-023 When PRESET=1 at a PCLK edge, the state SHALL become IDLE and PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and the wait counter SHALL become 0; cmd_ready SHALL be 1 on the cycle after reset.
REQ-024 Reset asserted mid-transfer (SETUP or ACCESS) SHALL abort the transfer without a rsp_valid pulse.
REQ-025 A command presented during a reset cycle SHALL NOT be accepted.

Configuration
REQ-026 Macro APB_MASTER_TIMEOUT_EN defined: an 8-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY[index]=0.
REQ-027 With APB_MASTER_TIMEOUT_EN defined, when the counter reaches TIMEOUT with PREADY still 0, the block SHALL drop PSEL and PENABLE, go to IDLE, and pulse rsp_valid with rsp_err=1 and rsp_rdata=0 on the next cycle.
REQ-028 With APB_MASTER_TIMEOUT_EN defined, PREADY=1 in the same cycle the counter reaches TIMEOUT SHALL complete the transfer normally, and no timeout SHALL occur.
REQ-029 Macro APB_MASTER_TIMEOUT_EN undefined: no counter logic SHALL exist, and ACCESS SHALL wait indefinitely.

Verification
REQ-030 Write, defaults, addr 0x005, data 0xA5, PREADY=1 immediately -> PSEL=2'b01, PENABLE at cycle 2, rsp_valid at cycle 3 with rsp_err=0.
REQ-031 Read at addr 0x10C, slave 1 PRDATA=0x3C, PREADY low for 3 cycles -> PSEL=2'b10, ACCESS lasts 4 cycles, rsp_rdata=0x3C.
REQ-032 Read with PSLVERR[0]=1 on the ready cycle -> rsp_err=1, rsp_rdata=PRDATA slice 0, and the next command is accepted at cycle 3.
REQ-033 NSLV=3, ADDR_W=9, addr 0x1C0 (index 3) -> PSEL=0 throughout, rsp_err=1 two cycles after accept.
REQ-034 APB_MASTER_TIMEOUT_EN defined, TIMEOUT=4, PREADY held 0 -> abort after 4 wait cycles, rsp_err=1; with the macro undefined, the block stays in ACCESS for 100 cycles.
REQ-035 PRESET=1 during ACCESS -> all outputs 0 the next cycle, no rsp_valid, cmd_ready=1 after reset.
